// File: rtl/pulse_mon_pkg.sv
// Shared types and default constants for the 1 Hz pulse monitor.
// Defaults describe a 50 MHz system clock.
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    localparam int ERR_CNT_W      = 8;
    localparam int DEF_NOM_PERIOD = 50_000_000;
    localparam int DEF_TOL        = 500;
    localparam int DEF_WIDTH_MAX  = 100;
    localparam int DEF_LOCK_COUNT = 3;
    localparam int DEF_CNT_W      = 26;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_1hz_monitor_sync_edge_det.sv
// Two-flop synchroniser for the asynchronous pulse input plus a delay flop
// for edge detection; rise and fall share the same latency.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // synchroniser chain and edge-delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/pulse_1hz_monitor.sv
// Receive-side checker for the 1 Hz timing pulse: measures period and width,
// tracks lock against the nominal period and flags early/missing/wide pulses.
module pulse_1hz_monitor
    import pulse_mon_pkg::*;
#(
    parameter int NOM_PERIOD = DEF_NOM_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int WIDTH_MAX  = DEF_WIDTH_MAX,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse_in,
    output logic [CNT_W-1:0]     period_meas,
    output logic [CNT_W-1:0]     width_meas,
    output logic                 meas_valid,
    output logic                 width_valid,
    output logic                 locked,
    output logic                 period_err,
    output logic                 pulse_missing,
    output logic                 width_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(NOM_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(NOM_PERIOD + TOL);
    localparam logic [CNT_W-1:0] W_ERR   = CNT_W'(WIDTH_MAX + 1);
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);

    logic w_level;
    logic w_rise;
    logic w_fall;

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_nxt;
    logic [CNT_W-1:0] w_pcnt_inc;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic [7:0]       r_good;
    logic [7:0]       w_good_nxt;
    logic [7:0]       w_good_inc;
    logic             w_early;
    logic             w_timeout;
    logic             w_mv;
    logic             w_perr;
    logic             w_miss;
    logic             w_werr;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pulse_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_pcnt_inc = r_pcnt + CNT_ONE;
    assign w_good_inc = r_good + 8'd1;
    assign w_early    = (w_pcnt_inc < WIN_LO);
    // a rise on the last in-window cycle takes priority over the timeout
    assign w_timeout  = (r_state != ST_SEARCH) && !w_rise && (w_pcnt_inc == WIN_HI);

    // lock FSM next-state, period counter and period strobes
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_pcnt_nxt  = r_pcnt;
        w_mv        = 1'b0;
        w_perr      = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                w_pcnt_nxt = {CNT_W{1'b0}};
                if (w_rise) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = 8'd0;
                end else begin
                    w_good_nxt  = r_good;
                end
            end
            ST_ACQUIRE: begin
                if (w_rise) begin
                    w_pcnt_nxt = {CNT_W{1'b0}};
                    w_mv       = 1'b1;
                    if (w_early) begin
                        w_perr     = 1'b1;
                        w_good_nxt = 8'd0;
                    end else if (w_good_inc == LOCK_N) begin
                        w_good_nxt  = w_good_inc;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = w_good_inc;
                    end
                end else if (w_timeout) begin
                    w_miss      = 1'b1;
                    w_state_nxt = ST_SEARCH;
                    w_pcnt_nxt  = {CNT_W{1'b0}};
                end else begin
                    w_pcnt_nxt = w_pcnt_inc;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    w_pcnt_nxt = {CNT_W{1'b0}};
                    w_mv       = 1'b1;
                    if (w_early) begin
                        w_perr      = 1'b1;
                        w_good_nxt  = 8'd0;
                        w_state_nxt = ST_ACQUIRE;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end else if (w_timeout) begin
                    w_miss      = 1'b1;
                    w_state_nxt = ST_SEARCH;
                    w_pcnt_nxt  = {CNT_W{1'b0}};
                end else begin
                    w_pcnt_nxt = w_pcnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = 8'd0;
                w_pcnt_nxt  = {CNT_W{1'b0}};
            end
        endcase
    end

    // width counter counts the rise cycle as 1, so the fall sees the full high time
    always_comb begin
        w_wcnt_nxt = r_wcnt;
        if (w_rise) begin
            w_wcnt_nxt = CNT_ONE;
        end else if (w_level && (r_wcnt != {CNT_W{1'b1}})) begin
            w_wcnt_nxt = r_wcnt + CNT_ONE;
        end else begin
            w_wcnt_nxt = r_wcnt;
        end
    end

    assign w_werr = w_level && (w_wcnt_nxt == W_ERR) && (w_rise || (r_wcnt != W_ERR));

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SEARCH;
            r_pcnt        <= {CNT_W{1'b0}};
            r_wcnt        <= {CNT_W{1'b0}};
            r_good        <= 8'd0;
            period_meas   <= {CNT_W{1'b0}};
            width_meas    <= {CNT_W{1'b0}};
            meas_valid    <= 1'b0;
            width_valid   <= 1'b0;
            locked        <= 1'b0;
            period_err    <= 1'b0;
            pulse_missing <= 1'b0;
            width_err     <= 1'b0;
            err_cnt       <= {ERR_CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_pcnt        <= w_pcnt_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_good        <= w_good_nxt;
            meas_valid    <= w_mv;
            width_valid   <= w_fall;
            locked        <= (w_state_nxt == ST_LOCKED);
            period_err    <= w_perr;
            pulse_missing <= w_miss;
            width_err     <= w_werr;
            if (w_mv) begin
                period_meas <= w_pcnt_inc;
            end
            if (w_fall) begin
                width_meas <= r_wcnt;
            end
            if (w_perr || w_miss) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pulse_1hz_monitor.sv
// Self-checking bench: directed and random pulse trains compared cycle by
// cycle against an event-level model of the monitor's rules.
module tb_pulse_1hz_monitor;

    localparam int NOM   = 1000;
    localparam int TOL   = 10;
    localparam int WMAX  = 100;
    localparam int LOCKN = 3;
    localparam int CW    = 26;
    localparam int MAXC  = 50000;
    localparam int MAXP  = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic [CW-1:0] period_meas;
    logic [CW-1:0] width_meas;
    logic          meas_valid;
    logic          width_valid;
    logic          locked;
    logic          period_err;
    logic          pulse_missing;
    logic          width_err;
    logic [7:0]    err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int p_start [MAXP];
    int p_width [MAXP];
    int n_p;
    int len;

    bit e_mv   [MAXC];
    bit e_wv   [MAXC];
    bit e_perr [MAXC];
    bit e_miss [MAXC];
    bit e_werr [MAXC];
    bit stim   [MAXC];
    int e_per  [MAXC];
    int e_wid  [MAXC];
    int lk_evt [MAXC];
    int e_lock [MAXC];
    int e_ecnt [MAXC];

    always #5 clk = ~clk;

    pulse_1hz_monitor #(
        .NOM_PERIOD (NOM),
        .TOL        (TOL),
        .WIDTH_MAX  (WMAX),
        .LOCK_COUNT (LOCKN),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pulse_in      (pulse_in),
        .period_meas   (period_meas),
        .width_meas    (width_meas),
        .meas_valid    (meas_valid),
        .width_valid   (width_valid),
        .locked        (locked),
        .period_err    (period_err),
        .pulse_missing (pulse_missing),
        .width_err     (width_err),
        .err_cnt       (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic add_pulse(input int gap, input int w);
        p_start[n_p] = (n_p == 0) ? gap : p_start[n_p-1] + gap;
        p_width[n_p] = w;
        n_p++;
    endtask

    // Event-level model: detected rise = pulse start + 2, outputs visible one cycle later.
    task automatic build_model();
        int mode;
        int ref_t;
        int good;
        int r;
        int d;
        int v;
        int lock;
        int ecnt;
        for (int k = 0; k < len; k++) begin
            e_mv[k] = 0; e_wv[k] = 0; e_perr[k] = 0; e_miss[k] = 0; e_werr[k] = 0;
            stim[k] = 0; e_per[k] = 0; e_wid[k] = 0; lk_evt[k] = -1;
        end
        for (int i = 0; i < n_p; i++)
            for (int c = p_start[i]; c < p_start[i] + p_width[i] && c < len; c++)
                stim[c] = 1;
        mode = 0; ref_t = 0; good = 0;
        for (int i = 0; i < n_p; i++) begin
            r = p_start[i] + 2;
            if (mode != 0 && r - ref_t > NOM + TOL) begin
                v = ref_t + NOM + TOL + 1;
                if (v < len) begin e_miss[v] = 1; lk_evt[v] = 0; end
                mode = 0;
            end
            if (mode == 0) begin
                mode = 1; good = 0; ref_t = r;
            end else begin
                d = r - ref_t; ref_t = r; v = r + 1;
                if (v < len) begin e_mv[v] = 1; e_per[v] = d; end
                if (d < NOM - TOL) begin
                    if (v < len) begin e_perr[v] = 1; lk_evt[v] = 0; end
                    mode = 1; good = 0;
                end else if (mode == 1) begin
                    good++;
                    if (good == LOCKN) begin
                        mode = 2;
                        if (v < len) lk_evt[v] = 1;
                    end
                end
            end
            v = r + p_width[i] + 1;
            if (v < len) begin e_wv[v] = 1; e_wid[v] = p_width[i]; end
            v = r + WMAX + 1;
            if (p_width[i] > WMAX && v < len) e_werr[v] = 1;
        end
        if (mode != 0) begin
            v = ref_t + NOM + TOL + 1;
            if (v < len) begin e_miss[v] = 1; lk_evt[v] = 0; end
        end
        lock = 0; ecnt = 0;
        for (int k = 0; k < len; k++) begin
            if (lk_evt[k] == 1) lock = 1;
            else if (lk_evt[k] == 0) lock = 0;
            if ((e_perr[k] || e_miss[k]) && ecnt < 255) ecnt++;
            e_lock[k] = lock;
            e_ecnt[k] = ecnt;
        end
    endtask

    task automatic run_phase();
        build_model();
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1 pulse_in = stim[k];
            @(negedge clk);
            check_eq("strobes", 32'({meas_valid, width_valid, period_err, pulse_missing, width_err}),
                     32'({e_mv[k], e_wv[k], e_perr[k], e_miss[k], e_werr[k]}));
            check_eq("locked", 32'(locked), 32'(e_lock[k]));
            check_eq("err_cnt", 32'(err_cnt), 32'(e_ecnt[k]));
            if (e_mv[k]) check_eq("period_meas", 32'(period_meas), 32'(e_per[k]));
            if (e_wv[k]) check_eq("width_meas", 32'(width_meas), 32'(e_wid[k]));
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_zero", 32'(|{period_meas, width_meas, meas_valid, width_valid, locked,
                                   period_err, pulse_missing, width_err, err_cnt}), 32'd0);
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sel;
        int gap;
        int w;
        apply_reset();

        // directed sequence: lock, early edge, window edges, timeouts, wide pulse
        n_p = 0;
        add_pulse(10, 50);
        repeat (4) add_pulse(1000, 50);
        add_pulse(980, 50);
        repeat (3) add_pulse(1000, 50);
        add_pulse(1010, 50);
        add_pulse(990, 50);
        add_pulse(1011, 50);
        repeat (3) add_pulse(1000, 50);
        add_pulse(1000, 150);
        add_pulse(1500, 50);
        repeat (4) add_pulse(1000, 50);
        len = p_start[n_p-1] + 20;
        run_phase();
        check_eq("locked_before_rst", 32'(locked), 32'd1);
        apply_reset();

        // randomized pulse train
        n_p = 0;
        add_pulse(10, 50);
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      gap = $urandom_range(990, 1010);
            else if (sel < 8) gap = $urandom_range(200, 989);
            else              gap = $urandom_range(1011, 1400);
            w = $urandom_range(1, 150);
            if (w >= gap) w = gap - 1;
            add_pulse(gap, w);
        end
        len = p_start[n_p-1] + 1500;
        run_phase();
        apply_reset();

        // burst of early edges to saturate the error counter
        n_p = 0;
        add_pulse(10, 5);
        repeat (261) add_pulse(20, 5);
        len = p_start[n_p-1] + 30;
        run_phase();
        check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
